// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with per-frame bit order, a single-entry
// output buffer with valid/ready handshake, and a sticky overrun flag.
module serial_deserializer #(
  parameter int Data_width = 5
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic                            MSB_FIRST,
  input  logic                            SVALID,
  input  logic                            SIN,
  input  logic                            Q_READY,
  input  logic                            CLR_OVR,
  output logic [Data_width-1:0]           Q,
  output logic                            Q_VALID,
  output logic                            BUSY,
  output logic [$clog2(Data_width+1)-1:0] BITCNT,
  output logic                            OVERRUN
);

  localparam int CW = $clog2(Data_width + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(Data_width - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [Data_width-1:0] sr_reg, sr_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  ord_reg, ord_next;
  logic [Data_width-1:0] q_reg, q_next;
  logic                  qv_reg, qv_next;
  logic                  ovr_reg, ovr_next;

  // Shift register contents after absorbing SIN in the latched bit order
  logic [Data_width-1:0] shifted;
  logic                  complete;

  // Compute the shift-register value that would result from taking SIN now
  always_comb begin
    shifted = '0;
    if (ord_reg) begin
      shifted = {sr_reg[Data_width-2:0], SIN};
    end else begin
      shifted = {SIN, sr_reg[Data_width-1:1]};
    end
  end

  // Next-state logic: frame FSM, output buffer handshake and overrun flag
  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    ord_next   = ord_reg;
    q_next     = q_reg;
    qv_next    = qv_reg;
    ovr_next   = ovr_reg;
    complete   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next = SHIFT;
          sr_next    = '0;
          cnt_next   = '0;
          ord_next   = MSB_FIRST;
        end
      end
      SHIFT: begin
        if (START) begin
          // Restart discards any partial frame, including one about to finish
          sr_next  = '0;
          cnt_next = '0;
          ord_next = MSB_FIRST;
        end else if (SVALID) begin
          sr_next = shifted;
          if (cnt_reg == LAST_IDX) begin
            complete   = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Buffer is free when empty or being drained on this very edge
    if (complete) begin
      if (!qv_reg || Q_READY) begin
        q_next  = shifted;
        qv_next = 1'b1;
      end
    end else if (qv_reg && Q_READY) begin
      qv_next = 1'b0;
    end

    // Setting an overrun takes priority over a simultaneous clear
    if (complete && qv_reg && !Q_READY) begin
      ovr_next = 1'b1;
    end else if (CLR_OVR) begin
      ovr_next = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      ord_reg   <= 1'b1;
      q_reg     <= '0;
      qv_reg    <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
      ord_reg   <= ord_next;
      q_reg     <= q_next;
      qv_reg    <= qv_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign Q       = q_reg;
  assign Q_VALID = qv_reg;
  assign BUSY    = (state_reg == SHIFT);
  assign BITCNT  = cnt_reg;
  assign OVERRUN = ovr_reg;

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: Data_width, default 5, word width in bits; legal range 2..32.
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RST_N  input  1  reset, asynchronous, active-low; one clock, no other reset.
REQ-004 START  input  1  frame start strobe.
REQ-005 MSB_FIRST  input  1  bit order for next frame; 1 = MSB first, 0 = LSB first.
REQ-006 SVALID  input  1  SIN carries a valid bit this cycle.
REQ-007 SIN  input  1  serial data bit.
REQ-008 Q_READY  input  1  consumer accepts Q this cycle.
REQ-009 CLR_OVR  input  1  clears OVERRUN.
REQ-010 Q  output  Data_width  assembled parallel word, registered.
REQ-011 Q_VALID  output  1  Q holds an unconsumed word.
REQ-012 BUSY  output  1  high while a frame is being assembled (state SHIFT).
REQ-013 BITCNT  output  $clog2(Data_width+1)  bits received in current frame.
REQ-014 OVERRUN  output  1  sticky: a completed word was dropped.

Function
REQ-015 Internal registers: shift register SR[Data_width-1:0], bit counter, latched order bit ORD, output buffer Q, state.
REQ-016 States: IDLE and SHIFT only; BUSY = (state == SHIFT).
REQ-017 IDLE: START=1 -> SHIFT; SR, BITCNT cleared; ORD <= MSB_FIRST; SVALID ignored that cycle.
REQ-018 SHIFT, SVALID=1, START=0: ORD=1 -> SR <= {SR[Data_width-2:0], SIN}; ORD=0 -> SR <= {SIN, SR[Data_width-1:1]}; BITCNT increments.
REQ-019 SHIFT, SVALID=0, START=0: SR, BITCNT, ORD hold (stall, unlimited length).
REQ-020 SHIFT, START=1: frame aborts and restarts exactly as REQ-017; partial bits discarded; no word produced; OVERRUN unaffected.
REQ-021 Completion: the edge sampling bit Data_width (BITCNT = Data_width-1, SVALID=1) forms word W = the shifted SR value; state -> IDLE; BITCNT -> 0.
REQ-022 On completion, if buffer free (Q_VALID=0, or Q_VALID=1 with Q_READY=1 same edge): Q <= W, Q_VALID <= 1; W visible one cycle after the last-bit edge (latency 1 clock).
REQ-023 On completion with Q_VALID=1 and Q_READY=0: W dropped, Q and Q_VALID unchanged, OVERRUN <= 1.
REQ-024 Handshake: Q_VALID=1 and Q_READY=1 at an edge with no completion -> Q_VALID <= 0; Q retains last value.
REQ-025 Q changes only on word load (REQ-022); Q stable while Q_VALID=1 and Q_READY=0.
REQ-026 Q_READY while Q_VALID=0: ignored.
REQ-027 OVERRUN: set per REQ-023; cleared by CLR_OVR=1; same-edge set and clear -> set wins.
REQ-028 MSB_FIRST changes mid-frame have no effect; only ORD latched at START is used.
REQ-029 START in the same cycle as the last bit: START wins; word not formed (REQ-020).

Reset
REQ-030 RST_N=0 asynchronously forces: state IDLE, SR=0, BITCNT=0, ORD=1, Q=0, Q_VALID=0, BUSY=0, OVERRUN=0.
REQ-031 Reset mid-frame or with Q_VALID=1: partial frame and buffered word lost; no output glitch beyond going to reset values.
REQ-032 After RST_N deasserts, the first START is accepted at the first posedge CLK with RST_N=1.

Verification (Data_width = 5)
REQ-033 START, MSB_FIRST=1, bits 1,0,1,1,0 on consecutive SVALID cycles, Q_READY=0 -> Q=5'b10110, Q_VALID=1 one cycle after bit 5, BUSY=0.
REQ-034 START, MSB_FIRST=0, bits 1,0,1,1,0 with SVALID gaps of 0-3 cycles -> Q=5'b01101, BITCNT holds during gaps.
REQ-035 Word A pending, Q_READY=0, second frame completes -> Q stays A, OVERRUN=1; CLR_OVR pulse -> OVERRUN=0; Q_READY pulse -> Q_VALID=0.
REQ-036 Word A pending, Q_READY=1 on same edge as second frame's last bit (word B) -> Q=B, Q_VALID=1, OVERRUN=0.
REQ-037 Three bits shifted, then START -> BITCNT=0, BUSY=1; five more bits 0,0,0,0,1 MSB-first -> Q=5'b00001.
REQ-038 RST_N low for one half-cycle mid-frame with Q_VALID=1 -> all outputs 0 immediately, before next CLK edge.
